// File: rtl/kp_serializer.sv
// kp_serializer
//
// Output-side serializer for the ECC scalar-multiplication datapath. Captures
// the affine result words kP.x and kP.y on a one-cycle start strobe and
// streams them over a narrow bus, most-significant nibble first: all of x,
// then all of y. A downstream hold freezes the stream without dropping or
// repeating nibbles. A one-cycle done pulse follows the last nibble.
//
// Parameters:
//   WORD_W  width of each result coordinate (default 32)
//   NIB_W   width of the output bus (default 4); WORD_W must be a multiple
//
// Ports:
//   i_clk    in   1       clock, rising edge
//   i_rst_n  in   1       asynchronous active-low reset
//   i_start  in   1       result words valid (ignored while busy)
//   i_x      in   WORD_W  kP.x, normal form
//   i_y      in   WORD_W  kP.y, normal form
//   i_hold   in   1       downstream stall, freezes the stream
//   o_busy   out  1       a frame is in flight
//   o_ready  out  1       o_kP carries a valid nibble this cycle
//   o_kP     out  NIB_W   current output nibble
//   o_done   out  1       one-cycle pulse after the last nibble

module kp_serializer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NIB_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_x,
  input  logic [WORD_W-1:0] i_y,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_ready,
  output logic [NIB_W-1:0]  o_kP,
  output logic              o_done
);

  localparam int unsigned NIBS = WORD_W / NIB_W;
  // Keep the counter at least one bit wide even for a single-nibble word.
  localparam int unsigned CntW = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NIBS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSendX,
    StSendY
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] x_q, x_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic              done_q, done_d;

  // A send cycle that is not stalled: the current nibble is consumed.
  logic advance;
  // The nibble on the bus is the last one of the current word.
  logic last;

  always_comb begin
    advance = (state_q != StIdle) && !i_hold;
    last    = (cnt_q == CntLast);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StSendX;
        end
      end
      StSendX: begin
        if (advance && last) begin
          state_d = StSendY;
        end
      end
      StSendY: begin
        if (advance && last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (registered state, shift registers and i_hold only)
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy  = 1'b0;
    o_ready = 1'b0;
    o_kP    = '0;
    unique case (state_q)
      StSendX: begin
        o_busy  = 1'b1;
        o_ready = !i_hold;
        o_kP    = x_q[WORD_W-1 -: NIB_W];
      end
      StSendY: begin
        o_busy  = 1'b1;
        o_ready = !i_hold;
        o_kP    = y_q[WORD_W-1 -: NIB_W];
      end
      default: begin
        o_busy  = 1'b0;
        o_ready = 1'b0;
        o_kP    = '0;
      end
    endcase
  end

  assign o_done = done_q;

  // ---------------------------------------------------------------------------
  // Datapath: capture, shift and nibble count
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          x_d   = i_x;
          y_d   = i_y;
          cnt_d = '0;
        end
      end
      StSendX: begin
        if (advance) begin
          x_d   = x_q << NIB_W;
          // The word change clears the count; it never wraps on its own.
          cnt_d = last ? '0 : cnt_q + CntW'(1);
        end
      end
      StSendY: begin
        if (advance) begin
          y_d    = y_q << NIB_W;
          cnt_d  = last ? '0 : cnt_q + CntW'(1);
          done_d = last;
        end
      end
      default: begin
        x_d    = x_q;
        y_d    = y_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_kp_serializer.sv
module tb_kp_serializer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_x;
  logic [31:0] i_y;
  logic        i_hold;
  logic        o_busy;
  logic        o_ready;
  logic [3:0]  o_kP;
  logic        o_done;

  kp_serializer #(
    .WORD_W(32),
    .NIB_W (4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_x    (i_x),
    .i_y    (i_y),
    .i_hold (i_hold),
    .o_busy (o_busy),
    .o_ready(o_ready),
    .o_kP   (o_kP),
    .o_done (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        start;
    logic        hold;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        ready;
    logic [3:0]  kp;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  // Reference model: a queue of nibbles still to be delivered.
  logic [3:0] mq[$];
  logic       m_done;

  task automatic cmp1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check(input string tag, input logic b, input logic r, input logic [3:0] k,
                       input logic d);
    cmp1({tag, ".busy"}, 32'(o_busy), 32'(b));
    cmp1({tag, ".ready"}, 32'(o_ready), 32'(r));
    cmp1({tag, ".kP"}, 32'(o_kP), 32'(k));
    cmp1({tag, ".done"}, 32'(o_done), 32'(d));
  endtask

  task automatic model_reset();
    mq.delete();
    m_done = 1'b0;
  endtask

  // What the model expects to see during the current cycle.
  task automatic model_out(input logic hd, output logic b, output logic r, output logic [3:0] k,
                           output logic d);
    b = (mq.size() != 0);
    r = b && !hd;
    k = b ? mq[0] : 4'h0;
    d = m_done;
  endtask

  // Effect of the clock edge that ends the current cycle.
  task automatic model_edge(input logic st, input logic [31:0] x, input logic [31:0] y,
                            input logic hd);
    logic [63:0] w;
    if (mq.size() != 0) begin
      m_done = !hd && (mq.size() == 1);
      if (!hd) void'(mq.pop_front());
    end else begin
      m_done = 1'b0;
      if (st) begin
        w = {x, y};
        for (int k = 0; k < 16; k++) mq.push_back(4'((w >> (60 - 4 * k)) & 64'hF));
      end
    end
  endtask

  task automatic cycle_model(input string tag, input logic st, input logic [31:0] x,
                             input logic [31:0] y, input logic hd);
    logic b, r, d;
    logic [3:0] k;
    i_start = st;
    i_x     = x;
    i_y     = y;
    i_hold  = hd;
    @(negedge i_clk);
    model_out(hd, b, r, k, d);
    check(tag, b, r, k, d);
    @(posedge i_clk);
    model_edge(st, x, y, hd);
    #1;
  endtask

  task automatic cycle_table(input int idx, input vec_t v);
    i_start = v.start;
    i_x     = v.x;
    i_y     = v.y;
    i_hold  = v.hold;
    @(negedge i_clk);
    check($sformatf("tbl[%0d]", idx), v.busy, v.ready, v.kp, v.done);
    @(posedge i_clk);
    model_edge(v.start, v.x, v.y, v.hold);
    #1;
  endtask

  function automatic vec_t mkv(input logic st, input logic hd, input logic [31:0] x,
                               input logic [31:0] y, input logic b, input logic r,
                               input logic [3:0] k, input logic d);
    vec_t v;
    v.start = st; v.hold = hd; v.x = x; v.y = y;
    v.busy = b; v.ready = r; v.kp = k; v.done = d;
    return v;
  endfunction

  initial begin
    logic [63:0] w;
    logic [3:0]  seq [16];
    int          sent;
    logic        hd;
    logic [31:0] rx, ry;

    // Expected nibble order of the reference words: 1..F, 0.
    w = {32'h1234_5678, 32'h9ABC_DEF0};
    for (int k = 0; k < 16; k++) seq[k] = 4'((w >> (60 - 4 * k)) & 64'hF);

    // Basic frame: start cycle, 16 valid cycles, done cycle, one idle cycle.
    tbl.push_back(mkv(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 4'h0, 0));
    for (int c = 1; c <= 16; c++) tbl.push_back(mkv(0, 0, 0, 0, 1, 1, seq[c-1], 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 4'h0, 0));

    // Held frame: hold in cycles 3-5 and 12, done in cycle 21.
    tbl.push_back(mkv(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 4'h0, 0));
    sent = 0;
    for (int c = 1; c <= 20; c++) begin
      hd = (c >= 3 && c <= 5) || (c == 12);
      tbl.push_back(mkv(0, hd, 0, 0, 1, !hd, seq[sent], 0));
      if (!hd) sent++;
    end
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 4'h0, 0));  // hold in idle does nothing

    // Reset held with start asserted: everything stays at zero.
    i_rst_n = 1'b0;
    i_start = 1'b1;
    i_x     = 32'hDEAD_BEEF;
    i_y     = 32'hCAFE_F00D;
    i_hold  = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge i_clk);
      check("reset", 0, 0, 4'h0, 0);
    end
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_rst_n = 1'b1;
    repeat (3) cycle_model("post_reset", 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);

    for (int i = 0; i < tbl.size(); i++) cycle_table(i, tbl[i]);

    // Start pulse in cycle 5 of a frame must be ignored.
    cycle_model("ign", 1, 32'hA5C3_0F96, 32'h7E18_42BD, 0);
    for (int c = 1; c <= 22; c++)
      cycle_model("ign", c == 5, (c == 5) ? 32'hFFFF_FFFF : 32'h0, 32'h0, 0);

    // Back-to-back: next start in the done cycle.
    cycle_model("b2b", 1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    for (int c = 1; c <= 16; c++) cycle_model("b2b", 0, 0, 0, 0);
    cycle_model("b2b_done", 1, 32'h0000_000F, 32'h0, 0);
    for (int c = 1; c <= 19; c++) cycle_model("b2b2", 0, 0, 0, 0);

    // Mid-frame reset in cycle 7.
    cycle_model("mrst", 1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    for (int c = 1; c <= 6; c++) cycle_model("mrst", 0, 0, 0, 0);
    i_rst_n = 1'b0;
    #1;
    check("mrst_async", 0, 0, 4'h0, 0);
    model_reset();
    @(posedge i_clk);
    #1;
    check("mrst_held", 0, 0, 4'h0, 0);
    i_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) cycle_model("mrst_idle", 0, 0, 0, 0);
    cycle_model("mrst_new", 1, 32'hC0FF_EE11, 32'h2468_ACE0, 0);
    for (int c = 1; c <= 18; c++) cycle_model("mrst_new", 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rx = $urandom;
      ry = $urandom;
      cycle_model("rand", $urandom_range(7) == 0, rx, ry, $urandom_range(3) == 0);
    end
    for (int c = 0; c < 40; c++) cycle_model("drain", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
